// File: rtl/reflet_interrupt_ctrl_pkg.sv
// Shared CPU constants used by the interrupt controller: instruction
// encodings it decodes and the register id of the program counter.
package reflet_interrupt_ctrl_pkg;

   localparam logic [3:0] opp_setint   = 4'hE;
   localparam logic [7:0] inst_setmask = 8'h0D;
   localparam logic [7:0] inst_retint  = 8'h0E;
   localparam logic [3:0] pc_id        = 4'd14;

endpackage

// File: rtl/reflet_interrupt_ctrl_if.sv
// CPU-side connection of the interrupt controller: the instruction/register
// inputs it observes and the register-write request it issues back.
interface reflet_interrupt_ctrl_if #(
   parameter int WORDSIZE = 16
);
   logic [7:0]          instruction;
   logic [WORDSIZE-1:0] working_register;
   logic [WORDSIZE-1:0] pc_in;
   logic                ram_not_ready;
   logic [WORDSIZE-1:0] out;
   logic [3:0]          out_reg;
   logic                int_strobe;

   modport master (
      output instruction, working_register, pc_in, ram_not_ready,
      input  out, out_reg, int_strobe
   );

   modport slave (
      input  instruction, working_register, pc_in, ram_not_ready,
      output out, out_reg, int_strobe
   );
endinterface

// File: rtl/reflet_int_stack.sv
// LIFO holding {return PC, previous level} for each nested interrupt.
// Push on a full stack or pop on an empty one is ignored.
module reflet_int_stack #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_top,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] r_sp;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_do_push;
   logic             w_do_pop;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_top_idx;

   assign o_full    = (r_sp == PTR_W'(DEPTH));
   assign o_empty   = (r_sp == '0);
   assign o_count   = r_sp;
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_wr_idx  = IDX_W'(r_sp);
   assign w_top_idx = IDX_W'(r_sp - PTR_W'(1));
   assign o_top     = r_mem[w_top_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp <= '0;
      end else if (w_do_push) begin
         r_sp <= r_sp + PTR_W'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - PTR_W'(1);
      end
   end

   // Entry contents are only meaningful below the pointer, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

endmodule

// File: rtl/reflet_interrupt_ctrl.sv
// Prioritised, nestable interrupt controller for the Reflet CPU: latches
// request edges, enters the lowest eligible channel and returns on retint.
module reflet_interrupt_ctrl
   import reflet_interrupt_ctrl_pkg::*;
#(
   parameter int WORDSIZE   = 16,
   parameter int NUM_INT    = 8,
   parameter int NEST_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_INT-1:0]     ext_int,
   reflet_interrupt_ctrl_if.slave bus
);
   localparam int LVL_W   = $clog2(NUM_INT + 1);
   localparam int CH_W    = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
   localparam int PTR_W   = $clog2(NEST_DEPTH + 1);
   localparam int ENTRY_W = WORDSIZE + LVL_W;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_FULL   = 2'd2;

   logic [NUM_INT-1:0]  r_ext_prev;
   logic [NUM_INT-1:0]  r_pending;
   logic [NUM_INT-1:0]  r_mask;
   logic [WORDSIZE-1:0] r_vector [NUM_INT];
   logic [LVL_W-1:0]    r_level;
   logic [1:0]          r_state;

   logic                w_is_setint;
   logic                w_setint_ok;
   logic                w_is_setmask;
   logic                w_is_retint;
   logic [CH_W-1:0]     w_setint_ch;
   logic [NUM_INT-1:0]  w_eligible;
   logic [NUM_INT-1:0]  w_clear;
   logic [CH_W-1:0]     w_chan;
   logic                w_has_elig;
   logic                w_entry;
   logic                w_pop;
   logic [ENTRY_W-1:0]  w_top;
   logic [PTR_W-1:0]    w_stk_count;
   logic                w_stk_full;
   logic                w_stk_empty;
   logic [WORDSIZE-1:0] w_out;
   logic [3:0]          w_out_reg;
   logic                w_int;

   assign w_is_setint  = (bus.instruction[7:4] == opp_setint);
   assign w_setint_ok  = w_is_setint && (int'(bus.instruction[3:0]) < NUM_INT);
   assign w_setint_ch  = CH_W'(bus.instruction[3:0]);
   assign w_is_setmask = (bus.instruction == inst_setmask);
   assign w_is_retint  = (bus.instruction == inst_retint);

   // Only channels strictly more urgent than the one being served may preempt.
   always_comb begin
      w_eligible = '0;
      w_chan     = '0;
      w_has_elig = 1'b0;
      for (int i = 0; i < NUM_INT; i++) begin
         w_eligible[i] = r_pending[i] & r_mask[i] & (LVL_W'(i) < r_level);
      end
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_chan     = CH_W'(i);
            w_has_elig = 1'b1;
         end
      end
   end

   assign w_entry = w_has_elig && !bus.ram_not_ready && !w_is_retint &&
                    (r_state != ST_FULL) && !w_stk_full;
   assign w_pop   = w_is_retint && (r_state != ST_IDLE) && !w_stk_empty;

   always_comb begin
      w_clear = '0;
      if (w_entry) begin
         w_clear[w_chan] = 1'b1;
      end
   end

   reflet_int_stack #(
      .WIDTH (ENTRY_W),
      .DEPTH (NEST_DEPTH)
   ) u_stack (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_entry),
      .i_pop   (w_pop),
      .i_data  ({bus.pc_in, r_level}),
      .o_top   (w_top),
      .o_count (w_stk_count),
      .o_full  (w_stk_full),
      .o_empty (w_stk_empty)
   );

   // A new rising edge wins over the clear of an entry taken on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ext_prev <= '0;
         r_pending  <= '0;
         r_mask     <= '1;
      end else begin
         r_ext_prev <= ext_int;
         r_pending  <= (r_pending & ~w_clear) | (ext_int & ~r_ext_prev);
         if (w_is_setmask) begin
            r_mask <= bus.working_register[NUM_INT-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_INT; i++) begin
            r_vector[i] <= '0;
         end
      end else if (w_setint_ok) begin
         r_vector[w_setint_ch] <= bus.working_register;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= LVL_W'(NUM_INT);
         r_state <= ST_IDLE;
      end else if (w_entry) begin
         r_level <= LVL_W'(w_chan);
         r_state <= (w_stk_count == PTR_W'(NEST_DEPTH - 1)) ? ST_FULL : ST_ACTIVE;
      end else if (w_pop) begin
         r_level <= w_top[LVL_W-1:0];
         r_state <= (w_stk_count == PTR_W'(1)) ? ST_IDLE : ST_ACTIVE;
      end
   end

   always_comb begin
      w_out     = '0;
      w_out_reg = '0;
      w_int     = 1'b0;
      if (!reset) begin
         if (w_entry) begin
            w_int     = 1'b1;
            w_out     = r_vector[w_chan];
            w_out_reg = pc_id;
         end else if (w_pop) begin
            w_out     = w_top[ENTRY_W-1 -: WORDSIZE];
            w_out_reg = pc_id;
         end else if (w_setint_ok || w_is_setmask) begin
            w_out = bus.working_register;
         end
      end
   end

   assign bus.out        = w_out;
   assign bus.out_reg    = w_out_reg;
   assign bus.int_strobe = w_int;

endmodule

// File: tb/tb_reflet_interrupt_ctrl.sv
// Directed bench for reflet_interrupt_ctrl: default-depth and depth-2 instances,
// expectations queued at stimulus time and checked by per-instance monitors.
module tb_reflet_interrupt_ctrl;

   localparam logic [7:0] NOP  = 8'h00;
   localparam logic [7:0] RET  = 8'h0E;
   localparam logic [7:0] SMSK = 8'h0D;
   localparam logic [3:0] PCID = 4'd14;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rst_q = 1'b1;
   logic [7:0] ext_a = '0;
   logic [7:0] ext_b = '0;

   int checks = 0;
   int errors = 0;

   logic [20:0] qa_exp [$];
   string       qa_nm  [$];
   logic [20:0] qb_exp [$];
   string       qb_nm  [$];

   logic [20:0] ea, aa, eb, ab;
   string       na, nb;

   reflet_interrupt_ctrl_if #(.WORDSIZE(16)) bus_a ();
   reflet_interrupt_ctrl_if #(.WORDSIZE(16)) bus_b ();

   reflet_interrupt_ctrl #(.WORDSIZE(16), .NUM_INT(8), .NEST_DEPTH(4)) u_dut_a (
      .clk     (clk),
      .reset   (reset),
      .ext_int (ext_a),
      .bus     (bus_a)
   );

   reflet_interrupt_ctrl #(.WORDSIZE(16), .NUM_INT(8), .NEST_DEPTH(2)) u_dut_b (
      .clk     (clk),
      .reset   (reset),
      .ext_int (ext_b),
      .bus     (bus_b)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus on the selected instance plus its expected outputs.
   task automatic step(input bit sel, input logic [7:0] ins, input logic [15:0] wr,
                       input logic [15:0] pc, input logic rnr, input logic [7:0] ext,
                       input logic ei, input logic [15:0] eo, input logic [3:0] er,
                       input string nm);
      @(posedge clk);
      #1;
      reset = rst_q;
      if (!sel) begin
         bus_a.instruction = ins; bus_a.working_register = wr;
         bus_a.pc_in = pc; bus_a.ram_not_ready = rnr; ext_a = ext;
         bus_b.instruction = NOP; bus_b.working_register = '0;
         bus_b.pc_in = '0; bus_b.ram_not_ready = 1'b0; ext_b = '0;
         qa_exp.push_back({ei, eo, er});
         qa_nm.push_back(nm);
      end else begin
         bus_b.instruction = ins; bus_b.working_register = wr;
         bus_b.pc_in = pc; bus_b.ram_not_ready = rnr; ext_b = ext;
         bus_a.instruction = NOP; bus_a.working_register = '0;
         bus_a.pc_in = '0; bus_a.ram_not_ready = 1'b0; ext_a = '0;
         qb_exp.push_back({ei, eo, er});
         qb_nm.push_back(nm);
      end
   endtask

   always @(negedge clk) begin
      if (qa_exp.size() > 0) begin
         ea = qa_exp.pop_front();
         na = qa_nm.pop_front();
         aa = {bus_a.int_strobe, bus_a.out, bus_a.out_reg};
         checks++;
         if (aa !== ea) begin
            errors++;
            $display("FAIL A.%s: got int=%0b out=%h out_reg=%0d, expected int=%0b out=%h out_reg=%0d",
                     na, aa[20], aa[19:4], aa[3:0], ea[20], ea[19:4], ea[3:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (qb_exp.size() > 0) begin
         eb = qb_exp.pop_front();
         nb = qb_nm.pop_front();
         ab = {bus_b.int_strobe, bus_b.out, bus_b.out_reg};
         checks++;
         if (ab !== eb) begin
            errors++;
            $display("FAIL B.%s: got int=%0b out=%h out_reg=%0d, expected int=%0b out=%h out_reg=%0d",
                     nb, ab[20], ab[19:4], ab[3:0], eb[20], eb[19:4], eb[3:0]);
         end
      end
   end

   initial begin
      bus_a.instruction = NOP; bus_a.working_register = '0;
      bus_a.pc_in = '0; bus_a.ram_not_ready = 1'b0;
      bus_b.instruction = NOP; bus_b.working_register = '0;
      bus_b.pc_in = '0; bus_b.ram_not_ready = 1'b0;

      // Reset, then a line already high at release counts as an edge
      step(0, 8'hE2, 16'h1234, 16'h0000, 0, 8'h80, 0, 16'h0000, 4'd0, "reset_out");
      rst_q = 1'b0;
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h80, 0, 16'h0000, 4'd0, "rel_quiet");
      step(0, NOP,   16'h0000, 16'h0200, 0, 8'h80, 1, 16'h0000, PCID, "rel_edge_ch7");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h80, 0, 16'h0200, PCID, "ret_ch7");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle");
      // setint ch2 then edge
      step(0, 8'hE2, 16'h0120, 16'h0000, 0, 8'h00, 0, 16'h0120, 4'd0, "setint_ch2");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h04, 0, 16'h0000, 4'd0, "edge_ch2");
      step(0, NOP,   16'h0000, 16'h0300, 0, 8'h04, 1, 16'h0120, PCID, "entry_ch2");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0300, PCID, "ret_ch2");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "post_ret");
      // Simultaneous ch1 and ch5
      step(0, 8'hE1, 16'h0111, 16'h0000, 0, 8'h00, 0, 16'h0111, 4'd0, "setint_ch1");
      step(0, 8'hE5, 16'h0555, 16'h0000, 0, 8'h00, 0, 16'h0555, 4'd0, "setint_ch5");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h22, 0, 16'h0000, 4'd0, "edge_ch1_ch5");
      step(0, NOP,   16'h0000, 16'h0400, 0, 8'h22, 1, 16'h0111, PCID, "entry_ch1_first");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h22, 0, 16'h0000, 4'd0, "ch5_waits");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h22, 0, 16'h0400, PCID, "ret_ch1");
      step(0, NOP,   16'h0000, 16'h0410, 0, 8'h22, 1, 16'h0555, PCID, "entry_ch5");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h22, 0, 16'h0410, PCID, "ret_ch5");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle2");
      // Nesting: ch3, then ch0 preempts, ch4 held
      step(0, 8'hE3, 16'h0333, 16'h0000, 0, 8'h00, 0, 16'h0333, 4'd0, "setint_ch3");
      step(0, 8'hE0, 16'h0F00, 16'h0000, 0, 8'h00, 0, 16'h0F00, 4'd0, "setint_ch0");
      step(0, 8'hE4, 16'h0444, 16'h0000, 0, 8'h00, 0, 16'h0444, 4'd0, "setint_ch4");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h08, 0, 16'h0000, 4'd0, "edge_ch3");
      step(0, NOP,   16'h0000, 16'h0500, 0, 8'h08, 1, 16'h0333, PCID, "entry_ch3");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h09, 0, 16'h0000, 4'd0, "edge_ch0");
      step(0, NOP,   16'h0000, 16'h0510, 0, 8'h09, 1, 16'h0F00, PCID, "nest_ch0");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h19, 0, 16'h0000, 4'd0, "edge_ch4");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h19, 0, 16'h0000, 4'd0, "ch4_held_a");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h19, 0, 16'h0510, PCID, "ret_ch0");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h19, 0, 16'h0000, 4'd0, "ch4_held_b");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h19, 0, 16'h0500, PCID, "ret_ch3");
      step(0, NOP,   16'h0000, 16'h0520, 0, 8'h19, 1, 16'h0444, PCID, "entry_ch4");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h19, 0, 16'h0520, PCID, "ret_ch4");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle3");
      // Mask
      step(0, SMSK,  16'hFF00, 16'h0000, 0, 8'h00, 0, 16'hFF00, 4'd0, "setmask_0");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h01, 0, 16'h0000, 4'd0, "edge_masked");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h01, 0, 16'h0000, 4'd0, "masked_ch0");
      step(0, SMSK,  16'h0001, 16'h0000, 0, 8'h01, 0, 16'h0001, 4'd0, "setmask_1");
      step(0, NOP,   16'h0000, 16'h0600, 0, 8'h01, 1, 16'h0F00, PCID, "entry_unmasked");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h01, 0, 16'h0600, PCID, "ret_unmasked");
      step(0, SMSK,  16'h00FF, 16'h0000, 0, 8'h01, 0, 16'h00FF, 4'd0, "setmask_ff");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle4");
      // Entry outranks setint on the bus, write still lands
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h04, 0, 16'h0000, 4'd0, "edge_ch2_b");
      step(0, 8'hE6, 16'h0666, 16'h0700, 0, 8'h04, 1, 16'h0120, PCID, "entry_over_setint");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h04, 0, 16'h0700, PCID, "ret_over_setint");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle5");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h40, 0, 16'h0000, 4'd0, "edge_ch6");
      step(0, NOP,   16'h0000, 16'h0710, 0, 8'h40, 1, 16'h0666, PCID, "vec6_written");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h40, 0, 16'h0710, PCID, "ret_ch6");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle6");
      // Re-rise coinciding with the clear keeps the request
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h04, 0, 16'h0000, 4'd0, "edge_ch2_c");
      step(0, NOP,   16'h0000, 16'h0000, 1, 8'h00, 0, 16'h0000, 4'd0, "rnr_block");
      step(0, NOP,   16'h0000, 16'h0800, 0, 8'h04, 1, 16'h0120, PCID, "entry_rerise");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h04, 0, 16'h0800, PCID, "ret_rerise");
      step(0, NOP,   16'h0000, 16'h0810, 0, 8'h04, 1, 16'h0120, PCID, "rerise_kept");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h04, 0, 16'h0810, PCID, "ret_kept");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle7");
      // ram_not_ready stall, then reset mid-service
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h01, 0, 16'h0000, 4'd0, "edge_ch0_b");
      step(0, NOP,   16'h0000, 16'h0000, 1, 8'h01, 0, 16'h0000, 4'd0, "rnr_hold_a");
      step(0, NOP,   16'h0000, 16'h0000, 1, 8'h01, 0, 16'h0000, 4'd0, "rnr_hold_b");
      step(0, NOP,   16'h0000, 16'h0900, 0, 8'h01, 1, 16'h0F00, PCID, "entry_after_rnr");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h01, 0, 16'h0000, 4'd0, "in_service");
      rst_q = 1'b1;
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h84, 0, 16'h0000, 4'd0, "mid_reset");
      rst_q = 1'b0;
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h84, 0, 16'h0000, 4'd0, "ret_after_reset");
      step(0, NOP,   16'h0000, 16'h0A00, 0, 8'h84, 1, 16'h0000, PCID, "rst_cleared_ch2");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h84, 0, 16'h0A00, PCID, "ret_rst_ch2");
      step(0, NOP,   16'h0000, 16'h0A10, 0, 8'h84, 1, 16'h0000, PCID, "ch7_level_reset");
      step(0, RET,   16'h0000, 16'h0000, 0, 8'h84, 0, 16'h0A10, PCID, "ret_rst_ch7");
      step(0, NOP,   16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 4'd0, "idle8");

      // Depth-2 instance: second nested level fills the stack
      step(1, 8'hE5, 16'h0B55, 16'h0000, 0, 8'h00, 0, 16'h0B55, 4'd0, "b_setint_ch5");
      step(1, 8'hE3, 16'h0B33, 16'h0000, 0, 8'h00, 0, 16'h0B33, 4'd0, "b_setint_ch3");
      step(1, 8'hE0, 16'h0B00, 16'h0000, 0, 8'h00, 0, 16'h0B00, 4'd0, "b_setint_ch0");
      step(1, NOP,   16'h0000, 16'h0000, 0, 8'h20, 0, 16'h0000, 4'd0, "b_edge_ch5");
      step(1, NOP,   16'h0000, 16'h1000, 0, 8'h20, 1, 16'h0B55, PCID, "b_entry_ch5");
      step(1, NOP,   16'h0000, 16'h0000, 0, 8'h28, 0, 16'h0000, 4'd0, "b_edge_ch3");
      step(1, NOP,   16'h0000, 16'h1010, 0, 8'h28, 1, 16'h0B33, PCID, "b_entry_ch3");
      step(1, NOP,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h0000, 4'd0, "b_edge_ch0");
      step(1, NOP,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h0000, 4'd0, "b_full_block_a");
      step(1, NOP,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h0000, 4'd0, "b_full_block_b");
      step(1, RET,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h1010, PCID, "b_ret_ch3");
      step(1, NOP,   16'h0000, 16'h1020, 0, 8'h29, 1, 16'h0B00, PCID, "b_entry_after_ret");
      step(1, RET,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h1020, PCID, "b_ret_ch0");
      step(1, RET,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h1000, PCID, "b_ret_ch5");
      step(1, RET,   16'h0000, 16'h0000, 0, 8'h29, 0, 16'h0000, 4'd0, "b_ret_empty");

      repeat (3) @(negedge clk);
      #1;
      if (qa_exp.size() != 0 || qb_exp.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d expectations left, expected 0/0",
                  qa_exp.size(), qb_exp.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reflet_interrupt_ctrl.md
REFLET_INTERRUPT_CTRL -- requirements
Module: reflet_interrupt_ctrl

Interface
REQ-001 SHALL have parameter WORDSIZE, default 16: CPU word width.
REQ-002 SHALL have parameter NUM_INT, default 8, legal 1..16: number of interrupt channels; channel 0 has highest priority.
REQ-003 SHALL have parameter NEST_DEPTH, default 4, legal 1..8: maximum simultaneously active (nested) interrupts.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port ext_int, input, NUM_INT bits: request lines, rising-edge sensitive.
REQ-007 SHALL have port instruction, input, 8 bits: current CPU instruction.
REQ-008 SHALL have port working_register, input, WORDSIZE bits: CPU working register value.
REQ-009 SHALL have port pc_in, input, WORDSIZE bits: return address to save on entry.
REQ-010 SHALL have port ram_not_ready, input, 1 bit: CPU stalled; no entry taken while high.
REQ-011 SHALL have port out, output, WORDSIZE bits: value the CPU writes to out_reg.
REQ-012 SHALL have port out_reg, output, 4 bits: destination register id; 0 means none.
REQ-013 SHALL have port int, output, 1 bit: one-cycle interrupt-entry strobe.

Function
REQ-014 SHALL set pending[i] on a 0->1 transition of ext_int[i], sampled on clk; levels alone SHALL NOT re-set it.
REQ-015 SHALL decode setint as opcode opp_setint in instruction[7:4] with channel index in instruction[3:0]: vector[idx] <= working_register; out = working_register; out_reg = 0; indices >= NUM_INT SHALL be ignored.
REQ-016 SHALL decode inst_setmask: mask <= working_register[NUM_INT-1:0]; out = working_register; out_reg = 0.
REQ-017 SHALL decode inst_retint: out = top-of-stack saved PC; out_reg = pc_id; pop on the same clk edge.
REQ-018 SHALL decode inst_retint on an empty stack as a no-op: out = 0, out_reg = 0.
REQ-019 SHALL define eligible channels as pending & mask with index < current level; level = NUM_INT when no interrupt is active.
REQ-020 SHALL take an entry when an eligible channel exists, ram_not_ready = 0, stack not full, and the instruction is not retint.
REQ-021 SHALL do the following in the entry cycle: int = 1; out = vector[c] for the lowest eligible index c; out_reg = pc_id; on the edge, push {pc_in, level}, set level = c, clear pending[c].
REQ-022 SHALL give an entry priority over a simultaneous setint/setmask: the register write still occurs, but out/out_reg carry the entry values.
REQ-023 SHALL let a rising edge on channel c coinciding with the clearing of pending[c] leave pending[c] set.
REQ-024 SHALL restore level from the popped entry on retint; re-evaluation occurs the following cycle.
REQ-025 SHALL use FSM states IDLE (stack empty), ACTIVE (1..NEST_DEPTH-1 entries), FULL (NEST_DEPTH entries; entries blocked, pending latched); transitions occur only on push/pop.
REQ-026 SHALL drive out = 0, out_reg = 0, int = 0 in all other cycles; out, out_reg and int are combinational from state and inputs.

Reset
REQ-027 SHALL, while reset is high, clear pending, set mask to all ones, clear vectors, set level = NUM_INT, set stack pointer = 0, set state = IDLE, and drive out/out_reg/int = 0.
REQ-028 SHALL discard stacked entries on reset mid-service, with no pop output.
REQ-029 SHALL capture the edge-detect history register as 0 on reset, so a line already high at release registers as an edge.

Structure
REQ-030 SHALL take opp_setint, inst_setmask, inst_retint and pc_id from the shared CPU constants package; the FSM state encoding is local.
REQ-031 SHALL implement the save stack as one sub-module, reflet_int_stack (push/pop LIFO, full/empty flags).

Verification
REQ-032 SHALL cover: setint ch2 with wr=0x0120, then edge on ext_int[2] -> next cycle int=1, out=0x0120, out_reg=pc_id.
REQ-033 SHALL cover: edges on ch5 and ch1 in the same cycle -> ch1 entered first; ch5 entered the cycle after its retint.
REQ-034 SHALL cover: serving ch3, edge on ch0 -> nested entry; edge on ch4 -> held pending until both retints.
REQ-035 SHALL cover: mask=0x00, edge ch0 -> no int; setmask 0x01 -> entry the next cycle.
REQ-036 SHALL cover: NEST_DEPTH=2 with both levels active, edge ch0 -> blocked in FULL; entry one cycle after a retint.
REQ-037 SHALL cover: ram_not_ready high with ch0 pending -> no int until it drops; reset mid-service -> stack empty, level=NUM_INT.
